micro_sequencer: RTL and testbench

//  Multicycle MIPS control sequencer. It walks each instruction through fetch, decode, execute, memory and writeback.
//  Per state it emits the 3-bit micro-op code consumed by the control decoder, plus the strobes that code does not carry.

---
 rtl/mips_ctrl_pkg.sv | 53 +++++
 rtl/micro_sequencer_if.sv | 27 ++
 rtl/useq_out_rom.sv | 42 ++++
 rtl/micro_sequencer.sv | 94 +++++++++
 tb/tb_micro_sequencer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: sequencer states,
// micro-op codes handed to the control decoder, opcodes and ALU operand selects.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_MEM_WR = 4'd7,
        S_WB_R   = 4'd8,
        S_WB_I   = 4'd9,
        S_WB_MEM = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_TRAP   = 4'd13
    } state_e;

    localparam logic [2:0] UOP_NONE    = 3'b000;
    localparam logic [2:0] UOP_REGDST  = 3'b001;
    localparam logic [2:0] UOP_PC_BR   = 3'b010;
    localparam logic [2:0] UOP_PC_J    = 3'b011;
    localparam logic [2:0] UOP_MEM2REG = 3'b100;
    localparam logic [2:0] UOP_MEMWR   = 3'b101;
    localparam logic [2:0] UOP_IRWR    = 3'b110;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef struct packed {
        logic [2:0] code;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic       reg_wr;
    } rom_out_t;

endpackage

// File: rtl/micro_sequencer_if.sv
// Control bundle between the IR/flags, the micro-sequencer and the downstream
// control decoder / datapath.
interface micro_sequencer_if;

    logic       en;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [2:0] code;
    logic       pc_wr;
    logic       reg_wr;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic       illegal;
    logic [3:0] state_o;

    modport master (
        input  en, opcode, zero, mem_ready,
        output code, pc_wr, reg_wr, alu_op, alu_src_b, illegal, state_o
    );

    modport slave (
        output en, opcode, zero, mem_ready,
        input  code, pc_wr, reg_wr, alu_op, alu_src_b, illegal, state_o
    );

endinterface

// File: rtl/useq_out_rom.sv
// Pure state -> {micro-op code, ALU op, ALU B select, regfile write} table.
// Strobes gated by inputs (pc_wr, en) are applied by the sequencer top.
module useq_out_rom
    import mips_ctrl_pkg::*;
(
    input  state_e   state_i,
    output rom_out_t rom_o
);

    always_comb begin
        // NOTE: every output gets a default before the case so no state leaves
        // a field unassigned, which would otherwise infer a latch.
        rom_o = '{code: UOP_NONE, alu_op: ALU_ADD, alu_src_b: SRCB_RT, reg_wr: 1'b0};
        case (state_i)
            S_FETCH: begin
                rom_o.code      = UOP_IRWR;
                rom_o.alu_src_b = SRCB_FOUR;
            end
            S_DECODE: rom_o.alu_src_b = SRCB_IMM_SH;
            S_EXEC_R: rom_o.alu_op    = ALU_FUNCT;
            S_EXEC_I: rom_o.alu_src_b = SRCB_IMM;
            S_ADDR:   rom_o.alu_src_b = SRCB_IMM;
            S_MEM_WR: rom_o.code      = UOP_MEMWR;
            S_WB_R: begin
                rom_o.code   = UOP_REGDST;
                rom_o.reg_wr = 1'b1;
            end
            S_WB_I:   rom_o.reg_wr    = 1'b1;
            S_WB_MEM: begin
                rom_o.code   = UOP_MEM2REG;
                rom_o.reg_wr = 1'b1;
            end
            S_BRANCH: begin
                rom_o.code   = UOP_PC_BR;
                rom_o.alu_op = ALU_SUB;
            end
            S_JUMP:   rom_o.code      = UOP_PC_J;
            default:  ;
        endcase
    end

endmodule

// File: rtl/micro_sequencer.sv
// Multicycle MIPS control sequencer: state register, opcode dispatch and the
// input-gated strobes; static per-state outputs come from useq_out_rom.
module micro_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter bit STALL_EN = 1'b1,
    parameter bit TRAP_EN  = 1'b1
)(
    input logic               clk,
    input logic               rst_n,
    micro_sequencer_if.master bus
);

    state_e   state_q, state_d;
    logic     illegal_q, illegal_d;
    logic     mem_ok;
    rom_out_t rom;

    assign mem_ok = STALL_EN ? bus.mem_ready : 1'b1;

    useq_out_rom u_rom (
        .state_i (state_q),
        .rom_o   (rom)
    );

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        if (bus.en) begin
            illegal_d = 1'b0;
            case (state_q)
                S_IDLE:   state_d = S_FETCH;
                S_FETCH:  state_d = mem_ok ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (bus.opcode)
                        OP_RTYPE:     state_d = S_EXEC_R;
                        OP_ADDI:      state_d = S_EXEC_I;
                        OP_LW, OP_SW: state_d = S_ADDR;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_J:         state_d = S_JUMP;
                        default: begin
                            if (TRAP_EN) begin
                                state_d = S_TRAP;
                            end else begin
                                state_d   = S_IDLE;
                                illegal_d = 1'b1;
                            end
                        end
                    endcase
                end
                S_EXEC_R: state_d = S_WB_R;
                S_EXEC_I: state_d = S_WB_I;
                // IR holds the opcode until the next fetch, so re-reading it here is safe.
                S_ADDR:   state_d = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: state_d = mem_ok ? S_WB_MEM : S_MEM_RD;
                S_MEM_WR: state_d = mem_ok ? S_FETCH : S_MEM_WR;
                S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
                S_TRAP:   state_d = S_TRAP;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        bus.code      = bus.en ? rom.code : UOP_NONE;
        bus.reg_wr    = bus.en & rom.reg_wr;
        bus.alu_op    = rom.alu_op;
        bus.alu_src_b = rom.alu_src_b;
        bus.illegal   = (state_q == S_TRAP) | illegal_q;
        bus.state_o   = state_q;
        bus.pc_wr     = 1'b0;
        if (bus.en) begin
            case (state_q)
                S_FETCH:  bus.pc_wr = mem_ok;
                S_BRANCH: bus.pc_wr = bus.zero;
                S_JUMP:   bus.pc_wr = 1'b1;
                default:  bus.pc_wr = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: a per-cycle vector table for the
// instruction flows plus hand-written reset, trap and enable-freeze sequences.
module tb_micro_sequencer;
    import mips_ctrl_pkg::*;

    typedef struct {
        string      name;
        logic       en;
        logic [5:0] op;
        logic       zero;
        logic       mr;
        logic [13:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[$];

    micro_sequencer_if bus ();
    micro_sequencer_if bus_nt ();

    assign bus_nt.en        = bus.en;
    assign bus_nt.opcode    = bus.opcode;
    assign bus_nt.zero      = bus.zero;
    assign bus_nt.mem_ready = bus.mem_ready;

    micro_sequencer #(.STALL_EN(1'b1), .TRAP_EN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    micro_sequencer #(.STALL_EN(1'b1), .TRAP_EN(1'b0)) dut_nt (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_nt)
    );

    always #5 clk = ~clk;

    // {state, code, pc_wr, reg_wr, alu_op, alu_src_b, illegal}
    function automatic logic [13:0] pk(state_e st, logic [2:0] c, logic pw, logic rw,
                                       logic [1:0] ao, logic [1:0] sb, logic il);
        return {st, c, pw, rw, ao, sb, il};
    endfunction

    function automatic vec_t v(string n, logic en, logic [5:0] op, logic z, logic mr,
                               logic [13:0] e);
        vec_t r;
        r.name = n; r.en = en; r.op = op; r.zero = z; r.mr = mr; r.exp = e;
        return r;
    endfunction

    function automatic logic [13:0] act0();
        return {bus.state_o, bus.code, bus.pc_wr, bus.reg_wr, bus.alu_op, bus.alu_src_b, bus.illegal};
    endfunction

    function automatic logic [13:0] act1();
        return {bus_nt.state_o, bus_nt.code, bus_nt.pc_wr, bus_nt.reg_wr,
                bus_nt.alu_op, bus_nt.alu_src_b, bus_nt.illegal};
    endfunction

    task automatic check(string name, logic [13:0] act, logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got state=%0d code=%b pc_wr=%b reg_wr=%b alu=%b srcb=%b ill=%b, expected state=%0d code=%b pc_wr=%b reg_wr=%b alu=%b srcb=%b ill=%b",
                     name, act[13:10], act[9:7], act[6], act[5], act[4:3], act[2:1], act[0],
                     exp[13:10], exp[9:7], exp[6], exp[5], exp[4:3], exp[2:1], exp[0]);
        end
    endtask

    task automatic drive(logic en, logic [5:0] op, logic z, logic mr);
        bus.en = en; bus.opcode = op; bus.zero = z; bus.mem_ready = mr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    localparam logic [13:0] E_IDLE   = {S_IDLE,   UOP_NONE, 1'b0, 1'b0, ALU_ADD, SRCB_RT, 1'b0};
    localparam logic [13:0] E_FETCH  = {S_FETCH,  UOP_IRWR, 1'b1, 1'b0, ALU_ADD, SRCB_FOUR, 1'b0};
    localparam logic [13:0] E_FSTALL = {S_FETCH,  UOP_IRWR, 1'b0, 1'b0, ALU_ADD, SRCB_FOUR, 1'b0};
    localparam logic [13:0] E_DECODE = {S_DECODE, UOP_NONE, 1'b0, 1'b0, ALU_ADD, SRCB_IMM_SH, 1'b0};

    initial begin
        rst_n = 1'b0;
        drive(1'b1, OP_RTYPE, 1'b0, 1'b1);
        @(negedge clk);
        check("reset_hold", act0(), 14'd0);
        tick();
        rst_n = 1'b1;

        vecs.push_back(v("r_idle",    1, OP_RTYPE, 0, 1, E_IDLE));
        vecs.push_back(v("r_fetch",   1, OP_RTYPE, 0, 1, E_FETCH));
        vecs.push_back(v("r_decode",  1, OP_RTYPE, 0, 1, E_DECODE));
        vecs.push_back(v("r_exec",    1, OP_RTYPE, 0, 1, pk(S_EXEC_R, 3'b000, 0, 0, 2'b10, 2'b00, 0)));
        vecs.push_back(v("r_wb",      1, OP_RTYPE, 0, 1, pk(S_WB_R,   3'b001, 0, 1, 2'b00, 2'b00, 0)));
        vecs.push_back(v("i_fetch",   1, OP_ADDI,  0, 1, E_FETCH));
        vecs.push_back(v("i_decode",  1, OP_ADDI,  0, 1, E_DECODE));
        vecs.push_back(v("i_exec",    1, OP_ADDI,  0, 1, pk(S_EXEC_I, 3'b000, 0, 0, 2'b00, 2'b10, 0)));
        vecs.push_back(v("i_wb",      1, OP_ADDI,  0, 1, pk(S_WB_I,   3'b000, 0, 1, 2'b00, 2'b00, 0)));
        vecs.push_back(v("lw_fstall", 1, OP_LW,    0, 0, E_FSTALL));
        vecs.push_back(v("lw_fetch",  1, OP_LW,    0, 1, E_FETCH));
        vecs.push_back(v("lw_decode", 1, OP_LW,    0, 1, E_DECODE));
        vecs.push_back(v("lw_addr",   1, OP_LW,    0, 1, pk(S_ADDR,   3'b000, 0, 0, 2'b00, 2'b10, 0)));
        vecs.push_back(v("lw_mrd0",   1, OP_LW,    0, 0, pk(S_MEM_RD, 3'b000, 0, 0, 2'b00, 2'b00, 0)));
        vecs.push_back(v("lw_mrd1",   1, OP_LW,    0, 0, pk(S_MEM_RD, 3'b000, 0, 0, 2'b00, 2'b00, 0)));
        vecs.push_back(v("lw_mrd2",   1, OP_LW,    0, 1, pk(S_MEM_RD, 3'b000, 0, 0, 2'b00, 2'b00, 0)));
        vecs.push_back(v("lw_wb",     1, OP_LW,    0, 1, pk(S_WB_MEM, 3'b100, 0, 1, 2'b00, 2'b00, 0)));
        vecs.push_back(v("sw_fetch",  1, OP_SW,    0, 1, E_FETCH));
        vecs.push_back(v("sw_decode", 1, OP_SW,    0, 1, E_DECODE));
        vecs.push_back(v("sw_addr",   1, OP_SW,    0, 1, pk(S_ADDR,   3'b000, 0, 0, 2'b00, 2'b10, 0)));
        vecs.push_back(v("sw_mwr0",   1, OP_SW,    0, 0, pk(S_MEM_WR, 3'b101, 0, 0, 2'b00, 2'b00, 0)));
        vecs.push_back(v("sw_mwr1",   1, OP_SW,    0, 1, pk(S_MEM_WR, 3'b101, 0, 0, 2'b00, 2'b00, 0)));
        vecs.push_back(v("bz_fetch",  1, OP_BEQ,   1, 1, E_FETCH));
        vecs.push_back(v("bz_decode", 1, OP_BEQ,   1, 1, E_DECODE));
        vecs.push_back(v("bz_branch", 1, OP_BEQ,   1, 1, pk(S_BRANCH, 3'b010, 1, 0, 2'b01, 2'b00, 0)));
        vecs.push_back(v("bn_fetch",  1, OP_BEQ,   0, 1, E_FETCH));
        vecs.push_back(v("bn_decode", 1, OP_BEQ,   0, 1, E_DECODE));
        vecs.push_back(v("bn_branch", 1, OP_BEQ,   0, 1, pk(S_BRANCH, 3'b010, 0, 0, 2'b01, 2'b00, 0)));
        vecs.push_back(v("j_fetch",   1, OP_J,     0, 1, E_FETCH));
        vecs.push_back(v("j_decode",  1, OP_J,     0, 1, E_DECODE));
        vecs.push_back(v("j_jump",    1, OP_J,     0, 1, pk(S_JUMP,   3'b011, 1, 0, 2'b00, 2'b00, 0)));
        vecs.push_back(v("f_en0",     0, OP_SW,    0, 1, pk(S_FETCH,  3'b000, 0, 0, 2'b00, 2'b01, 0)));
        vecs.push_back(v("f_en0b",    0, OP_SW,    0, 1, pk(S_FETCH,  3'b000, 0, 0, 2'b00, 2'b01, 0)));
        vecs.push_back(v("f_en1",     1, OP_SW,    0, 1, E_FETCH));

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].op, vecs[i].zero, vecs[i].mr);
            @(negedge clk);
            check(vecs[i].name, act0(), vecs[i].exp);
            tick();
        end

        // Asynchronous reset while a store is waiting on memory.
        drive(1, OP_SW, 0, 1);
        tick();
        tick();
        drive(1, OP_SW, 0, 0);
        @(negedge clk);
        check("mwr_before_rst", act0(), pk(S_MEM_WR, 3'b101, 0, 0, 2'b00, 2'b00, 0));
        #2 rst_n = 1'b0;
        #1 check("mwr_async_rst", act0(), 14'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", act0(), E_IDLE);
        tick();
        @(negedge clk);
        check("post_rst_fetch", act0(), E_FSTALL);

        // Undefined opcode: sticky TRAP vs. one-cycle illegal pulse.
        tick();
        do_reset();
        drive(1, 6'b111111, 0, 1);
        @(negedge clk);
        check("trap_idle", act0(), E_IDLE);
        tick();
        @(negedge clk);
        check("trap_fetch", act0(), E_FETCH);
        tick();
        @(negedge clk);
        check("trap_decode", act0(), E_DECODE);
        check("nt_decode", act1(), E_DECODE);
        tick();
        @(negedge clk);
        check("nt_illegal_pulse", act1(), pk(S_IDLE, 3'b000, 0, 0, 2'b00, 2'b00, 1));
        for (int k = 0; k < 10; k++) begin
            check($sformatf("trap_hold%0d", k), act0(), pk(S_TRAP, 3'b000, 0, 0, 2'b00, 2'b00, 1));
            if (k == 1) check("nt_refetch", act1(), E_FETCH);
            tick();
            @(negedge clk);
        end

        // en low while in write-back must suppress and then deliver one reg_wr.
        tick();
        do_reset();
        drive(1, OP_RTYPE, 0, 1);
        repeat (4) tick();
        drive(0, OP_RTYPE, 0, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("wbr_en0_%0d", k), act0(), pk(S_WB_R, 3'b000, 0, 0, 2'b00, 2'b00, 0));
            tick();
        end
        drive(1, OP_RTYPE, 0, 1);
        @(negedge clk);
        check("wbr_en1", act0(), pk(S_WB_R, 3'b001, 0, 1, 2'b00, 2'b00, 0));
        tick();
        @(negedge clk);
        check("wbr_next_fetch", act0(), E_FETCH);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
